// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access sizes, LSU FSM state encodings and the
// two-beat byte-enable mask helper.
package lsu_pkg;

    // Access size encoding, shared with the decoder's mem_size field.
    typedef enum logic [2:0] {
        MEM_BYTE = 3'b000,
        MEM_HALF = 3'b001,
        MEM_WORD = 3'b010
    } mem_size_e;

    // FSM state encoding kept as plain constants for legacy tools.
    typedef logic [2:0] lsu_state_e;
    localparam lsu_state_e IDLE  = 3'd0;
    localparam lsu_state_e BEAT0 = 3'd1;
    localparam lsu_state_e WAIT0 = 3'd2;
    localparam lsu_state_e BEAT1 = 3'd3;
    localparam lsu_state_e WAIT1 = 3'd4;
    localparam lsu_state_e RESP  = 3'd5;
    localparam lsu_state_e ERR   = 3'd6;

    // Bits [3:0] are the lanes of the first beat, bits [7:4] those of the next word.
    function automatic logic [7:0] be_mask(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            MEM_BYTE: base = 8'b0000_0001;
            MEM_HALF: base = 8'b0000_0011;
            MEM_WORD: base = 8'b0000_1111;
            default:  base = 8'b0000_0000;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: rotates store data onto its byte lanes and
// re-assembles/extends load data from the two-word merge buffer.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        unsign,
    input  logic [31:0] st_data,
    output logic [31:0] st_lanes,
    input  logic [63:0] ld_buf,
    output logic [31:0] ld_data
);

    logic [4:0]  sh;
    logic [31:0] raw;

    // Rotate store data left by the byte offset; extract and extend load data.
    always_comb begin
        sh       = {off, 3'b000};
        // A shift by 32 yields 0, so off=0 degenerates to a plain copy.
        st_lanes = (st_data << sh) | (st_data >> (6'd32 - {1'b0, sh}));
        raw      = 32'(ld_buf >> sh);
        case (size)
            MEM_BYTE: ld_data = {{24{~unsign & raw[7]}}, raw[7:0]};
            MEM_HALF: ld_data = {{16{~unsign & raw[15]}}, raw[15:0]};
            default:  ld_data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: turns one byte/half/word access into one or two word-aligned
// bus beats with byte enables and returns one response per request.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          SPLIT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic                  req_wren,
    input  logic [2:0]            req_size,
    input  logic                  req_unsign,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [4:0]            resp_rd,
    output logic                  resp_err,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [31:0]           bus_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  load_q, we_q, unsign_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            rd_q;
    logic [63:0]           mbuf_q, mbuf_d;

    logic [7:0]            req_mask, mask;
    logic                  req_illegal, split;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [3:0]            beat_be;
    logic [31:0]           wdata_rot, load_data;

    lsu_align u_align (
        .off      (addr_q[1:0]),
        .size     (size_q),
        .unsign   (unsign_q),
        .st_data  (wdata_q),
        .st_lanes (wdata_rot),
        .ld_buf   (mbuf_q),
        .ld_data  (load_data)
    );

    // Request legality and lane masks for the incoming and the captured access.
    always_comb begin
        req_mask    = be_mask(req_size, req_addr[1:0]);
        req_illegal = !(req_size == MEM_BYTE || req_size == MEM_HALF || req_size == MEM_WORD)
                      || (req_load == req_wren)
                      || (!SPLIT_EN && (|req_mask[7:4]));
        mask        = be_mask(size_q, addr_q[1:0]);
        split       = |mask[7:4];
        word_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    end

    // Next-state logic and merge-buffer lane capture.
    always_comb begin
        state_d = state_q;
        mbuf_d  = mbuf_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_illegal ? ERR : BEAT0;
                    mbuf_d  = '0;
                end
            end
            BEAT0: begin
                if (bus_ready) state_d = !we_q ? WAIT0 : (split ? BEAT1 : RESP);
            end
            WAIT0: begin
                if (bus_rvalid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mask[i]) mbuf_d[8*i +: 8] = bus_rdata[8*i +: 8];
                    end
                    state_d = split ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                if (bus_ready) state_d = we_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (bus_rvalid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mask[4+i]) mbuf_d[32+8*i +: 8] = bus_rdata[8*i +: 8];
                    end
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured request and merge buffer; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            load_q   <= 1'b0;
            we_q     <= 1'b0;
            unsign_q <= 1'b0;
            size_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            mbuf_q   <= '0;
        end else begin
            state_q <= state_d;
            mbuf_q  <= mbuf_d;
            if (state_q == IDLE && req_valid) begin
                load_q   <= req_load;
                we_q     <= req_wren;
                unsign_q <= req_unsign;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
            end
        end
    end

    // Moore outputs: bus fields only during beats, response fields only in RESP/ERR.
    always_comb begin
        req_ready = (state_q == IDLE);
        bus_valid = (state_q == BEAT0) || (state_q == BEAT1);
        bus_we    = bus_valid && we_q;
        beat_be   = 4'b0000;
        bus_addr  = '0;
        if (state_q == BEAT0) begin
            beat_be  = mask[3:0];
            bus_addr = word_addr;
        end else if (state_q == BEAT1) begin
            beat_be  = mask[7:4];
            bus_addr = word_addr + ADDR_WIDTH'(4);
        end
        bus_be    = beat_be;
        bus_wdata = '0;
        if (bus_we) begin
            for (int i = 0; i < 4; i++) begin
                if (beat_be[i]) bus_wdata[8*i +: 8] = wdata_rot[8*i +: 8];
            end
        end
        resp_valid = (state_q == RESP) || (state_q == ERR);
        resp_err   = (state_q == ERR);
        resp_rd    = resp_valid ? rd_q : 5'd0;
        resp_rdata = (state_q == RESP && load_q) ? load_data : 32'd0;
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: aligned/split loads and stores, address wrap,
// back-pressure, illegal requests, SPLIT_EN=0 and reset in the middle of a load.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_ns;
    logic        req_load, req_wren, req_unsign;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        req_ready, resp_valid, resp_err, bus_valid, bus_we;
    logic [31:0] resp_rdata, bus_addr, bus_wdata;
    logic [4:0]  resp_rd;
    logic [3:0]  bus_be;

    logic        req_ready_ns, resp_valid_ns, resp_err_ns, bus_valid_ns, bus_we_ns;
    logic [31:0] resp_rdata_ns, bus_addr_ns, bus_wdata_ns;
    logic [4:0]  resp_rd_ns;
    logic [3:0]  bus_be_ns;

    int checks = 0;
    int errors = 0;

    wire [69:0] bus_vec     = {bus_valid, bus_we, bus_addr, bus_be, bus_wdata};
    wire [38:0] resp_vec    = {resp_valid, resp_err, resp_rd, resp_rdata};
    wire [69:0] bus_vec_ns  = {bus_valid_ns, bus_we_ns, bus_addr_ns, bus_be_ns, bus_wdata_ns};
    wire [38:0] resp_vec_ns = {resp_valid_ns, resp_err_ns, resp_rd_ns, resp_rdata_ns};

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_WIDTH(32), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_wren(req_wren), .req_size(req_size),
        .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_err(resp_err), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    lsu_mem_port #(.ADDR_WIDTH(32), .SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
        .req_load(req_load), .req_wren(req_wren), .req_size(req_size),
        .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns),
        .resp_rd(resp_rd_ns), .resp_err(resp_err_ns), .bus_valid(bus_valid_ns),
        .bus_ready(bus_ready), .bus_we(bus_we_ns), .bus_addr(bus_addr_ns), .bus_be(bus_be_ns),
        .bus_wdata(bus_wdata_ns), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request to the main DUT (ns=0) or the non-splitting DUT (ns=1).
    task automatic issue(input logic ld, input logic wr, input logic [2:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic ns);
        req_load = ld; req_wren = wr; req_size = sz; req_unsign = u;
        req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = !ns; req_valid_ns = ns;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, req_ready_ns} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b want 11", {req_ready, req_ready_ns});
        end
        checks++;
        if ({bus_vec, resp_vec} !== 109'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {bus_vec, resp_vec});
        end
        checks++;
        if ({bus_vec_ns, resp_vec_ns} !== 109'd0) begin
            errors++; $display("FAIL reset_outputs_ns: got %h want 0", {bus_vec_ns, resp_vec_ns});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_store_word();
        logic [69:0] eb;
        logic [38:0] er;
        issue(1'b0, 1'b1, 3'b010, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 1'b0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL sw_ready: got %b want 1", req_ready);
        end
        step();
        req_valid = 1'b0;
        eb = {1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF};
        checks++;
        if ({bus_vec, resp_valid} !== {eb, 1'b0}) begin
            errors++; $display("FAIL sw_beat: got %h want %h", {bus_vec, resp_valid}, {eb, 1'b0});
        end
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        er = {1'b1, 1'b0, 5'd3, 32'h0};
        checks++;
        if (resp_vec !== er) begin
            errors++; $display("FAIL sw_resp: got %h want %h", resp_vec, er);
        end
        step();
        checks++;
        if ({req_ready, resp_vec} !== {1'b1, 39'd0}) begin
            errors++; $display("FAIL sw_idle: got %h want %h", {req_ready, resp_vec}, {1'b1, 39'd0});
        end
    endtask

    task automatic test_load_aligned();
        logic [31:0] t_addr [4] = '{32'h203, 32'h203, 32'h106, 32'h104};
        logic [2:0]  t_size [4] = '{3'b000, 3'b000, 3'b001, 3'b010};
        logic        t_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_word [4] = '{32'h80AABBCC, 32'h80AABBCC, 32'h80011234, 32'h80011234};
        logic [31:0] t_wa   [4] = '{32'h200, 32'h200, 32'h104, 32'h104};
        logic [3:0]  t_be   [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1111};
        logic [31:0] t_res  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h80011234};
        logic [69:0] eb;
        logic [38:0] er;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, 5'(7 + i), 1'b0);
            step();
            req_valid = 1'b0;
            eb = {1'b1, 1'b0, t_wa[i], t_be[i], 32'h0};
            checks++;
            if (bus_vec !== eb) begin
                errors++; $display("FAIL ld_beat[%0d]: got %h want %h", i, bus_vec, eb);
            end
            bus_ready = 1'b1;
            step();
            bus_ready = 1'b0;
            checks++;
            if ({bus_valid, resp_valid} !== 2'b00) begin
                errors++; $display("FAIL ld_wait[%0d]: got %b want 00", i, {bus_valid, resp_valid});
            end
            bus_rvalid = 1'b1;
            bus_rdata  = t_word[i];
            step();
            bus_rvalid = 1'b0;
            er = {1'b1, 1'b0, 5'(7 + i), t_res[i]};
            checks++;
            if (resp_vec !== er) begin
                errors++; $display("FAIL ld_resp[%0d]: got %h want %h", i, resp_vec, er);
            end
            step();
        end
    endtask

    task automatic test_load_split();
        logic [31:0] t_addr [2] = '{32'h102, 32'hFFFFFFFE};
        logic [31:0] t_a0   [2] = '{32'h100, 32'hFFFFFFFC};
        logic [31:0] t_a1   [2] = '{32'h104, 32'h00000000};
        logic [31:0] t_lo   [2] = '{32'h33221100, 32'hA1B2C3D4};
        logic [31:0] t_hi   [2] = '{32'h77665544, 32'h11223344};
        logic [31:0] t_res  [2] = '{32'h55443322, 32'h3344A1B2};
        logic [69:0] eb;
        logic [38:0] er;
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b0, 3'b010, 1'b0, t_addr[i], 32'h0, 5'd12, 1'b0);
            step();
            req_valid = 1'b0;
            eb = {1'b1, 1'b0, t_a0[i], 4'b1100, 32'h0};
            checks++;
            if (bus_vec !== eb) begin
                errors++; $display("FAIL lws_beat0[%0d]: got %h want %h", i, bus_vec, eb);
            end
            bus_ready = 1'b1;
            step();
            bus_ready  = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = t_lo[i];
            step();
            bus_rvalid = 1'b0;
            eb = {1'b1, 1'b0, t_a1[i], 4'b0011, 32'h0};
            checks++;
            if (bus_vec !== eb) begin
                errors++; $display("FAIL lws_beat1[%0d]: got %h want %h", i, bus_vec, eb);
            end
            bus_ready = 1'b1;
            step();
            bus_ready  = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = t_hi[i];
            step();
            bus_rvalid = 1'b0;
            er = {1'b1, 1'b0, 5'd12, t_res[i]};
            checks++;
            if (resp_vec !== er) begin
                errors++; $display("FAIL lws_resp[%0d]: got %h want %h", i, resp_vec, er);
            end
            step();
        end
    endtask

    task automatic test_store_split();
        logic [69:0] eb;
        logic [38:0] er;
        issue(1'b0, 1'b1, 3'b001, 1'b0, 32'h103, 32'h0000ABCD, 5'd5, 1'b0);
        step();
        req_valid = 1'b0;
        eb = {1'b1, 1'b1, 32'h100, 4'b1000, 32'hCD000000};
        checks++;
        if (bus_vec !== eb) begin
            errors++; $display("FAIL shs_beat0: got %h want %h", bus_vec, eb);
        end
        bus_ready = 1'b1;
        step();
        eb = {1'b1, 1'b1, 32'h104, 4'b0001, 32'h000000AB};
        checks++;
        if (bus_vec !== eb) begin
            errors++; $display("FAIL shs_beat1: got %h want %h", bus_vec, eb);
        end
        step();
        bus_ready = 1'b0;
        er = {1'b1, 1'b0, 5'd5, 32'h0};
        checks++;
        if (resp_vec !== er) begin
            errors++; $display("FAIL shs_resp: got %h want %h", resp_vec, er);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [71:0] ex;
        issue(1'b0, 1'b1, 3'b010, 1'b0, 32'h104, 32'h12345678, 5'd9, 1'b0);
        step();
        req_valid = 1'b0;
        ex = {1'b0, 1'b1, 1'b1, 32'h104, 4'b1111, 32'h12345678, 1'b0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({req_ready, bus_vec, resp_valid} !== ex) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i, {req_ready, bus_vec, resp_valid}, ex);
            end
            if (i == 3) bus_ready = 1'b1;
            step();
        end
        bus_ready = 1'b0;
        checks++;
        if (resp_vec !== {1'b1, 1'b0, 5'd9, 32'h0}) begin
            errors++; $display("FAIL bp_resp: got %h want %h", resp_vec, {1'b1, 1'b0, 5'd9, 32'h0});
        end
        step();
        checks++;
        if ({bus_valid, resp_valid} !== 2'b00) begin
            errors++; $display("FAIL bp_single: got %b want 00", {bus_valid, resp_valid});
        end
    endtask

    task automatic test_illegal();
        logic [2:0] t_size [3] = '{3'b011, 3'b010, 3'b000};
        logic       t_ld   [3] = '{1'b1, 1'b1, 1'b0};
        logic       t_wr   [3] = '{1'b0, 1'b1, 1'b0};
        logic [39:0] ex;
        for (int i = 0; i < 3; i++) begin
            issue(t_ld[i], t_wr[i], t_size[i], 1'b0, 32'h300, 32'hFFFFFFFF, 5'(20 + i), 1'b0);
            step();
            req_valid = 1'b0;
            ex = {1'b0, 1'b1, 1'b1, 5'(20 + i), 32'h0};
            checks++;
            if ({bus_valid, resp_vec} !== ex) begin
                errors++; $display("FAIL illegal[%0d]: got %h want %h", i, {bus_valid, resp_vec}, ex);
            end
            step();
            checks++;
            if ({req_ready, resp_valid} !== 2'b10) begin
                errors++; $display("FAIL illegal_idle[%0d]: got %b want 10", i, {req_ready, resp_valid});
            end
        end
    endtask

    task automatic test_no_split();
        logic [39:0] ex;
        issue(1'b1, 1'b0, 3'b010, 1'b0, 32'h101, 32'h0, 5'd17, 1'b1);
        step();
        req_valid_ns = 1'b0;
        ex = {1'b0, 1'b1, 1'b1, 5'd17, 32'h0};
        checks++;
        if ({bus_valid_ns, resp_vec_ns} !== ex) begin
            errors++; $display("FAIL nosplit: got %h want %h", {bus_valid_ns, resp_vec_ns}, ex);
        end
        step();
        checks++;
        if ({req_ready_ns, bus_valid_ns, resp_valid_ns} !== 3'b100) begin
            errors++;
            $display("FAIL nosplit_idle: got %b want 100", {req_ready_ns, bus_valid_ns, resp_valid_ns});
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 3'b010, 1'b0, 32'h100, 32'h0, 5'd4, 1'b0);
        step();
        req_valid = 1'b0;
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({req_ready, bus_vec, resp_vec} !== {1'b1, 109'd0}) begin
            errors++;
            $display("FAIL rst_mid: got %h want %h", {req_ready, bus_vec, resp_vec}, {1'b1, 109'd0});
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            step();
            bus_rvalid = 1'b0;
            checks++;
            if ({resp_valid, bus_valid} !== 2'b00) begin
                errors++; $display("FAIL rst_late_rvalid[%0d]: got %b want 00", i, {resp_valid, bus_valid});
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid_ns = 1'b0;
        req_load = 1'b0; req_wren = 1'b0; req_size = 3'b000; req_unsign = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1;
        test_reset();
        test_store_word();
        test_load_aligned();
        test_load_split();
        test_store_split();
        test_backpressure();
        test_illegal();
        test_no_split();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
